board_mem_arbiter: RTL and testbench
====================================

Name: board_mem_arbiter

Overview:
- Shares the single-port board/tile RAM between three requesters:
  - VGA scan-out fetch (highest priority)
  - 2048 game move engine (read/write)
  - debug/score reader
- Issues one registered memory access per cycle and returns read data, tagged, to the requester that issued it.
- Gates game writes to vertical blank so a board update never tears mid-frame.

Parameters:
- AW, 13, address width (matches the existing 13-bit board address bus)
- DW, 32, data width of one board cell word
- MEM_LAT, 1, RAM read latency in cycles after mem_en (1..3)
- WR_VBLANK_ONLY, 1, when 1 game writes are eligible only while vblank=1
- STARVE_MAX, 15, wait cycles after which a pending debug request outranks the game engine

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- vblank  in  1  high during vertical blanking, from the VGA timing logic
- vga_req  in  1  VGA fetch request
- vga_addr  in  AW  VGA fetch address
- vga_gnt  out  1  VGA request accepted
- vga_rvalid  out  1  vga_rdata valid
- vga_rdata  out  DW  VGA read data
- g_req  in  1  game request
- g_we  in  1  1=write, 0=read
- g_addr  in  AW  game address
- g_wdata  in  DW  game write data
- g_gnt  out  1  game request accepted
- g_rvalid  out  1  g_rdata valid
- g_rdata  out  DW  game read data
- d_req  in  1  debug read request
- d_addr  in  AW  debug address
- d_gnt  out  1  debug request accepted
- d_rvalid  out  1  d_rdata valid
- d_rdata  out  DW  debug read data
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data

Behaviour:
- Reset (async, rst_n=0): all gnt, rvalid, mem_en and mem_we = 0; mem_addr, mem_wdata and all rdata = 0; rr_ptr = game; starve_cnt = 0; tag pipeline cleared. Outputs stay at these values until the first rising clk edge after rst_n is released.
- Request rules: a requester holds req/addr/we/wdata stable until it sees gnt=1 in the cycle after it asserted req. gnt is a single-cycle pulse per accepted access. Dropping req before gnt is legal and cancels the request.
- Eligibility: game is eligible when g_req=1 and (g_we=0 or WR_VBLANK_ONLY=0 or vblank=1).
- Arbitration at cycle T, from combinational request inputs:
  - vga_req wins unconditionally.
  - Otherwise, if starve_cnt >= STARVE_MAX and d_req=1, debug wins.
  - Otherwise, between eligible game and d_req, round-robin starting at rr_ptr.
  - The winner's gnt, mem_en, mem_we, mem_addr and mem_wdata are registered and appear at T+1.
  - rr_ptr advances past the winner only when game or debug wins.
- starve_cnt: increments (saturating at STARVE_MAX) each cycle d_req=1 and debug is not granted; clears on d_gnt or when d_req=0.
- Read return: a tag pipeline of MEM_LAT stages carries {valid, owner} from T+1. At T+1+MEM_LAT, mem_rdata is registered into the owner's rdata and its rvalid pulses for one cycle.
  - Non-owner rdata holds its last value.
  - Writes push no tag and produce no rvalid.
- Back-to-back: one access per cycle sustained. Returns are in issue order, with at most MEM_LAT+1 reads in flight.
- Simultaneous events:
  - A vblank fall in the same cycle as a game-write request makes the request ineligible that cycle.
  - Reset mid-operation discards in-flight tags; no rvalid is emitted after reset.
- Idle: with no winner, mem_en=0 and mem_we=0; mem_addr and mem_wdata hold their values.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, no requests -> all gnt/rvalid/mem_en = 0 and rr_ptr=game; with MEM_LAT=1, no rvalid ever appears.
- VGA priority: vga_req, g_req (read) and d_req all high at T, vga_addr=0x800 -> vga_gnt=1, mem_addr=0x800 at T+1; vga_rvalid with mem_rdata=0x00100002 at T+2; g_gnt and d_gnt stay 0 while vga_req persists.
- Round-robin: vga idle, g_req read 0x804 and d_req 0x808 held continuously -> grants alternate game, debug, game, ...; each rvalid goes to the correct owner with the correct data.
- Vblank write gating: g_req=1, g_we=1, g_addr=0x810, g_wdata=0x3 with vblank=0 for 20 cycles -> no g_gnt. vblank rises at cycle 21 -> g_gnt=1, mem_we=1, mem_addr=0x810 and mem_wdata=0x3 at cycle 22.
- Starvation: STARVE_MAX=15, game requests continuously and wins ties from rr_ptr=game, d_req held -> d_gnt occurs no later than 16 cycles after d_req rises; starve_cnt returns to 0.
- Reset mid-read: MEM_LAT=3, three reads issued, rst_n pulsed low while they are in flight -> no rvalid after rst_n deasserts, all outputs return to reset values.

Source files
------------

// File: rtl/board_mem_arbiter.sv
// board_mem_arbiter: shares the single-port board/tile RAM between VGA scan-out,
// the 2048 move engine and the debug/score reader. One registered access per
// cycle; read data returns in issue order, steered to the requester that issued it.
// Game writes can be confined to vertical blank so the visible board never tears.
module board_mem_arbiter #(
    parameter int AW             = 13,
    parameter int DW             = 32,
    parameter int MEM_LAT        = 1,
    parameter bit WR_VBLANK_ONLY = 1'b1,
    parameter int STARVE_MAX     = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vblank,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic          vga_gnt,
    output logic          vga_rvalid,
    output logic [DW-1:0] vga_rdata,
    input  logic          g_req,
    input  logic          g_we,
    input  logic [AW-1:0] g_addr,
    input  logic [DW-1:0] g_wdata,
    output logic          g_gnt,
    output logic          g_rvalid,
    output logic [DW-1:0] g_rdata,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int            SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1);

    typedef enum logic [1:0] {
        OWN_VGA  = 2'd0,
        OWN_GAME = 2'd1,
        OWN_DBG  = 2'd2,
        OWN_NONE = 2'd3
    } owner_e;

    // Round-robin pointer: which of game/debug gets the next tie.
    typedef enum logic {
        RR_GAME = 1'b0,
        RR_DBG  = 1'b1
    } rr_e;

    owner_e             win_s;
    logic               g_elig_s;
    logic               rd_issue_s;
    rr_e                rr_ptr_r;
    rr_e                rr_ptr_nxt_s;
    logic [SW-1:0]      starve_cnt_r;
    logic [SW-1:0]      starve_nxt_s;
    logic [MEM_LAT-1:0] tag_v_r;
    owner_e             tag_own_r [MEM_LAT];

    // Pick this cycle's winner and derive round-robin / starvation next state.
    always_comb begin
        g_elig_s     = g_req & (~g_we | ~WR_VBLANK_ONLY | vblank);
        win_s        = OWN_NONE;
        rr_ptr_nxt_s = rr_ptr_r;
        starve_nxt_s = {SW{1'b0}};

        if (vga_req) begin
            win_s = OWN_VGA;
        end else if (d_req && (starve_cnt_r >= STARVE_LIM)) begin
            win_s = OWN_DBG;
        end else if (g_elig_s && d_req) begin
            win_s = (rr_ptr_r == RR_GAME) ? OWN_GAME : OWN_DBG;
        end else if (g_elig_s) begin
            win_s = OWN_GAME;
        end else if (d_req) begin
            win_s = OWN_DBG;
        end else begin
            win_s = OWN_NONE;
        end

        case (win_s)
            OWN_GAME: rr_ptr_nxt_s = RR_DBG;
            OWN_DBG:  rr_ptr_nxt_s = RR_GAME;
            default:  rr_ptr_nxt_s = rr_ptr_r;
        endcase

        if (d_req && (win_s != OWN_DBG)) begin
            starve_nxt_s = (starve_cnt_r >= STARVE_LIM) ? STARVE_LIM : (starve_cnt_r + STARVE_ONE);
        end else begin
            starve_nxt_s = {SW{1'b0}};
        end

        rd_issue_s = (win_s != OWN_NONE) && !((win_s == OWN_GAME) && g_we);
    end

    // Register grants, the RAM command and the arbitration state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_gnt      <= 1'b0;
            g_gnt        <= 1'b0;
            d_gnt        <= 1'b0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= {AW{1'b0}};
            mem_wdata    <= {DW{1'b0}};
            rr_ptr_r     <= RR_GAME;
            starve_cnt_r <= {SW{1'b0}};
        end else begin
            vga_gnt      <= (win_s == OWN_VGA);
            g_gnt        <= (win_s == OWN_GAME);
            d_gnt        <= (win_s == OWN_DBG);
            mem_en       <= (win_s != OWN_NONE);
            mem_we       <= (win_s == OWN_GAME) && g_we;
            rr_ptr_r     <= rr_ptr_nxt_s;
            starve_cnt_r <= starve_nxt_s;
            case (win_s)
                OWN_VGA:  mem_addr <= vga_addr;
                OWN_GAME: begin
                    mem_addr  <= g_addr;
                    mem_wdata <= g_wdata;
                end
                OWN_DBG:  mem_addr <= d_addr;
                default:  mem_addr <= mem_addr;
            endcase
        end
    end

    // Carry {valid, owner} of each issued read alongside the RAM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v_r <= {MEM_LAT{1'b0}};
            for (int i = 0; i < MEM_LAT; i++) begin
                tag_own_r[i] <= OWN_NONE;
            end
        end else begin
            tag_v_r[0]   <= rd_issue_s;
            tag_own_r[0] <= win_s;
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_v_r[i]   <= tag_v_r[i-1];
                tag_own_r[i] <= tag_own_r[i-1];
            end
        end
    end

    // Capture returning RAM data into the owning requester's read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_rvalid <= 1'b0;
            g_rvalid   <= 1'b0;
            d_rvalid   <= 1'b0;
            vga_rdata  <= {DW{1'b0}};
            g_rdata    <= {DW{1'b0}};
            d_rdata    <= {DW{1'b0}};
        end else begin
            vga_rvalid <= 1'b0;
            g_rvalid   <= 1'b0;
            d_rvalid   <= 1'b0;
            if (tag_v_r[MEM_LAT-1]) begin
                case (tag_own_r[MEM_LAT-1])
                    OWN_VGA: begin
                        vga_rvalid <= 1'b1;
                        vga_rdata  <= mem_rdata;
                    end
                    OWN_GAME: begin
                        g_rvalid <= 1'b1;
                        g_rdata  <= mem_rdata;
                    end
                    OWN_DBG: begin
                        d_rvalid <= 1'b1;
                        d_rdata  <= mem_rdata;
                    end
                    default: vga_rvalid <= 1'b0;
                endcase
            end else begin
                vga_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_board_mem_arbiter.sv
// tb_board_mem_arbiter: randomized and directed stimulus against a cycle-level
// reference model of the arbiter (priority rules, wait counting, return queue).
module tb_board_mem_arbiter;

    localparam int AW   = 13;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int SMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vblank;
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic          vga_gnt, vga_rvalid;
    logic [DW-1:0] vga_rdata;
    logic          g_req, g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;
    logic          g_gnt, g_rvalid;
    logic [DW-1:0] g_rdata;
    logic          d_req;
    logic [AW-1:0] d_addr;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    board_mem_arbiter #(
        .AW(AW), .DW(DW), .MEM_LAT(LAT), .WR_VBLANK_ONLY(1'b1), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vblank(vblank),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata),
        .g_gnt(g_gnt), .g_rvalid(g_rvalid), .g_rdata(g_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // RAM contents are a fixed function of the address.
    function automatic logic [DW-1:0] ramfn(input logic [AW-1:0] a);
        return {3'b001, a, 3'b010, a} ^ 32'h0000_00A5;
    endfunction

    // RAM model: data for the address presented LAT-1 cycles earlier.
    logic [AW-1:0] ahist [0:3];
    always @(posedge clk) begin
        ahist[0] <= mem_addr;
        for (int i = 1; i < 4; i++) ahist[i] <= ahist[i-1];
    end
    assign mem_rdata = ramfn((LAT == 1) ? mem_addr : ahist[(LAT >= 2) ? LAT - 2 : 0]);

    // Reference model state.
    typedef struct {
        int            due;
        int            own;
        logic [AW-1:0] addr;
    } ret_t;

    ret_t          retq[$];
    int            cyc;
    int            d_wait;
    bit            game_first;
    int            n_pass;
    int            n_chk;
    logic          e_vg, e_gg, e_dg, e_en, e_we, e_vrv, e_grv, e_drv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_vrd, e_grd, e_drd;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check_val("vga_gnt",    32'(vga_gnt),    32'(e_vg));
        check_val("g_gnt",      32'(g_gnt),      32'(e_gg));
        check_val("d_gnt",      32'(d_gnt),      32'(e_dg));
        check_val("mem_en",     32'(mem_en),     32'(e_en));
        check_val("mem_we",     32'(mem_we),     32'(e_we));
        check_val("mem_addr",   32'(mem_addr),   32'(e_addr));
        check_val("mem_wdata",  mem_wdata,       e_wdata);
        check_val("vga_rvalid", 32'(vga_rvalid), 32'(e_vrv));
        check_val("g_rvalid",   32'(g_rvalid),   32'(e_grv));
        check_val("d_rvalid",   32'(d_rvalid),   32'(e_drv));
        check_val("vga_rdata",  vga_rdata,       e_vrd);
        check_val("g_rdata",    g_rdata,         e_grd);
        check_val("d_rdata",    d_rdata,         e_drd);
    endtask

    task automatic model_reset();
        retq.delete();
        cyc = 0; d_wait = 0; game_first = 1'b1;
        e_vg = 1'b0; e_gg = 1'b0; e_dg = 1'b0; e_en = 1'b0; e_we = 1'b0;
        e_vrv = 1'b0; e_grv = 1'b0; e_drv = 1'b0;
        e_addr = '0; e_wdata = '0; e_vrd = '0; e_grd = '0; e_drd = '0;
    endtask

    // Predict outputs after the next rising edge from the inputs now applied.
    task automatic model_next();
        int   win;
        bit   g_ok;
        ret_t r;
        cyc++;
        e_vrv = 1'b0; e_grv = 1'b0; e_drv = 1'b0;
        if (retq.size() > 0 && retq[0].due == cyc) begin
            r = retq.pop_front();
            if (r.own == 0) begin e_vrv = 1'b1; e_vrd = ramfn(r.addr); end
            else if (r.own == 1) begin e_grv = 1'b1; e_grd = ramfn(r.addr); end
            else begin e_drv = 1'b1; e_drd = ramfn(r.addr); end
        end
        g_ok = g_req && (!g_we || vblank);
        if (vga_req) win = 0;
        else if (d_req && d_wait >= SMAX) win = 2;
        else if (g_ok && d_req) win = game_first ? 1 : 2;
        else if (g_ok) win = 1;
        else if (d_req) win = 2;
        else win = 3;
        if (win == 1) game_first = 1'b0;
        else if (win == 2) game_first = 1'b1;
        d_wait = (d_req && win != 2) ? d_wait + 1 : 0;
        e_vg = (win == 0); e_gg = (win == 1); e_dg = (win == 2);
        e_en = (win != 3);
        e_we = (win == 1) && g_we;
        if (win == 0) e_addr = vga_addr;
        if (win == 1) begin e_addr = g_addr; e_wdata = g_wdata; end
        if (win == 2) e_addr = d_addr;
        if (win != 3 && !e_we) retq.push_back('{cyc + LAT, win, e_addr});
    endtask

    task automatic cycle();
        model_next();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_inputs();
        vga_req = 1'b0; g_req = 1'b0; d_req = 1'b0; g_we = 1'b0;
    endtask

    // Pull reset low mid-cycle, hold it n cycles, release on a falling edge.
    task automatic mid_reset(input int n);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        model_reset();
        check_outputs();
        repeat (n) begin
            @(negedge clk);
            check_outputs();
        end
        rst_n = 1'b1;
    endtask

    // Random requesters that keep their fields stable until granted.
    task automatic rand_inputs();
        if (!vga_req || e_vg) vga_addr = AW'($urandom_range(0, 8191));
        vga_req = ($urandom_range(0, 3) == 0);
        if (!g_req || e_gg) begin
            g_we    = 1'($urandom_range(0, 1));
            g_addr  = AW'($urandom_range(0, 8191));
            g_wdata = $urandom();
        end
        g_req = ($urandom_range(0, 2) != 0);
        if (!d_req || e_dg) d_addr = AW'($urandom_range(0, 8191));
        d_req = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) vblank = ~vblank;
    endtask

    initial begin
        n_pass = 0; n_chk = 0;
        rst_n = 1'b0; vblank = 1'b0;
        idle_inputs();
        vga_addr = '0; g_addr = '0; g_wdata = '0; d_addr = '0;
        model_reset();

        // Reset then idle.
        @(negedge clk);
        check_outputs();
        repeat (3) begin
            @(negedge clk);
            check_outputs();
        end
        rst_n = 1'b1;
        repeat (4) cycle();

        // VGA outranks everyone while it requests, then game/debug alternate.
        vga_req = 1'b1; vga_addr = 13'h800;
        g_req = 1'b1; g_we = 1'b0; g_addr = 13'h804;
        d_req = 1'b1; d_addr = 13'h808;
        repeat (4) cycle();
        vga_req = 1'b0;
        repeat (8) cycle();
        idle_inputs();
        repeat (3) cycle();

        // Game write held off until vblank.
        g_req = 1'b1; g_we = 1'b1; g_addr = 13'h810; g_wdata = 32'h0000_0003;
        vblank = 1'b0;
        repeat (20) cycle();
        vblank = 1'b1;
        repeat (2) cycle();
        idle_inputs();
        vblank = 1'b0;
        repeat (2) cycle();

        // Starvation: debug overtakes the game once it has waited long enough.
        d_req = 1'b1; d_addr = 13'h820;
        cycle();
        vga_req = 1'b1; vga_addr = 13'h830;
        g_req = 1'b1; g_we = 1'b0; g_addr = 13'h840;
        repeat (20) cycle();
        vga_req = 1'b0;
        repeat (6) cycle();
        idle_inputs();
        repeat (3) cycle();

        // Reset while reads are in flight.
        for (int i = 0; i < 3; i++) begin
            vga_req = 1'b1;
            vga_addr = AW'(13'h900 + i);
            cycle();
        end
        mid_reset(2);
        repeat (6) cycle();

        // Random traffic, another mid-stream reset, more random traffic.
        repeat (1500) begin
            rand_inputs();
            cycle();
        end
        mid_reset(1);
        repeat (4) cycle();
        repeat (500) begin
            rand_inputs();
            cycle();
        end
        idle_inputs();
        repeat (LAT + 3) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
